octal_serial_sub: RTL

Bit-serial subtractor for two unsigned multi-digit octal operands. It returns the sign-magnitude difference |a − b| with a sign flag. A single `full_sub` cell is time-multiplexed LSB-first over all 3·DIGITS bits, with a registered borrow loop. The block sits directly upstream of, and wraps, the `full_sub` cell: it sequences operand bits into the cell and consumes its `diff`/`borrow` outputs. It presents valid/ready handshakes to the octal datapath on both sides.

---
 rtl/octal_sub_pkg.sv | 21 ++
 rtl/full_sub.sv | 14 +
 rtl/octal_serial_sub.sv | 118 +++++++++++
 3 files changed

// File: rtl/octal_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial octal subtractor.
package octal_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } sub_state_e;

    localparam int unsigned DIGITS_DEF = 4;

    // Three bits per octal digit.
    function automatic int unsigned width_f(input int unsigned digits);
        return 3 * digits;
    endfunction

    localparam int unsigned W_DEF     = 3 * DIGITS_DEF;
    localparam int unsigned CNT_W_DEF = $clog2(W_DEF + 1);

endpackage

// File: rtl/full_sub.sv
// One-bit full subtractor: diff = ain - bin - cin, borrow out when negative.
module full_sub (
    output logic borrow,
    output logic diff,
    input  logic ain,
    input  logic bin,
    input  logic cin
);
    // Pure combinational cell.
    always_comb begin
        diff   = ain ^ bin ^ cin;
        borrow = (~ain & bin) | (~(ain ^ bin) & cin);
    end
endmodule

// File: rtl/octal_serial_sub.sv
// Bit-serial |a - b| over octal-packed operands using one time-multiplexed
// full_sub cell, LSB first, with a registered borrow loop and a final
// two's-complement fix-up when the overall borrow indicates a < b.
module octal_serial_sub
    import octal_sub_pkg::*;
#(
    parameter int unsigned DIGITS = DIGITS_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [3*DIGITS-1:0]        a,
    input  logic [3*DIGITS-1:0]        b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [3*DIGITS-1:0]        diff,
    output logic                       neg,
    output logic                       zero
);
    localparam int unsigned W  = width_f(DIGITS);
    localparam int unsigned CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    sub_state_e    state_q, state_d;
    logic [W-1:0]  a_sr_q, a_sr_d;
    logic [W-1:0]  b_sr_q, b_sr_d;
    logic [W-1:0]  res_q, res_d;
    logic          borrow_q, borrow_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          neg_q, neg_d;
    logic          zero_q, zero_d;

    logic          cell_diff, cell_borrow;
    logic [W-1:0]  fixed;

    full_sub u_cell (
        .borrow (cell_borrow),
        .diff   (cell_diff),
        .ain    (a_sr_q[0]),
        .bin    (b_sr_q[0]),
        .cin    (borrow_q)
    );

    // Magnitude correction: negate the raw difference when it wrapped.
    assign fixed = borrow_q ? (~res_q + W'(1)) : res_q;

    // Next-state and datapath sequencing.
    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        zero_d   = zero_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_sr_d   = a;
                    b_sr_d   = b;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = ST_SUB;
                end
            end
            ST_SUB: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                res_d    = {cell_diff, res_q[W-1:1]};
                borrow_d = cell_borrow;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) state_d = ST_FIX;
            end
            ST_FIX: begin
                res_d   = fixed;
                neg_d   = borrow_q;
                zero_d  = (fixed == '0);
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset dominates any handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            zero_q   <= zero_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign diff      = res_q;
    assign neg       = neg_q;
    assign zero      = zero_q;

endmodule
